if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/load_use_detect.sv | 15 +
 rtl/if_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath/register-address widths and the fetch state encoding.
package pipeline_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds the instruction in ID; r0 never creates a hazard.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  output logic                  lu
);

  assign lu = idex_memread && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage control: load-use stalls, branch redirects (held across imem wait) and stall counting.
// state      | meaning
// RUN        | normal fetch, redirects applied immediately
// REDIR_WAIT | taken branch seen while imem busy; target held in pend_pc
module if_fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   imem_ready,
  input  logic                   idex_memread,
  input  logic [REG_ADDR_W-1:0]  idex_rt,
  input  logic [REG_ADDR_W-1:0]  ifid_rs,
  input  logic [REG_ADDR_W-1:0]  ifid_rt,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_target,
  output logic                   pc_write,
  output logic                   pc_redirect,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   ifid_write,
  output logic                   if_flush,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e    state, next_state;
  logic [XLEN-1:0] pend_pc, pend_next;
  logic            lu;

  load_use_detect u_lu (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .lu           (lu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state   <= next_state;
      pend_pc <= pend_next;
    end
  end

  always_comb begin
    next_state  = state;
    pend_next   = pend_pc;
    pc_write    = 1'b1;
    pc_redirect = 1'b0;
    redirect_pc = pend_pc;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      // Outputs are forced safe during reset, independent of the clock.
      next_state  = RUN;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      if_flush    = 1'b1;
      idex_bubble = 1'b1;
      redirect_pc = '0;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (state == RUN && branch_taken) begin
      ifid_write = 1'b0;
      if_flush   = 1'b1;
      if (imem_ready) begin
        pc_redirect = 1'b1;
        redirect_pc = branch_target;
      end else begin
        pc_write   = 1'b0;
        pend_next  = branch_target;
        next_state = REDIR_WAIT;
      end
    end else if (state == REDIR_WAIT) begin
      // Whatever imem returns here is the wrong path, so it is always flushed.
      ifid_write = 1'b0;
      if_flush   = 1'b1;
      if (imem_ready) begin
        pc_redirect = 1'b1;
        next_state  = RUN;
      end else begin
        pc_write = 1'b0;
      end
    end else if (!imem_ready) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_write && stall_cycles != STALL_MAX) begin
      stall_cycles <= stall_cycles + STALL_ONE;
    end
  end

  a_no_branch_in_redir_wait : assert property (
    @(posedge clk) disable iff (!rst_n) !(state == REDIR_WAIT && branch_taken)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a rule-level model checked every cycle plus literal spot checks.
module tb_if_fetch_ctrl;
  localparam int W = 3;
  localparam int SMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_ready = 1'b0;
  logic          idex_memread = 1'b0;
  logic [4:0]    idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_target = '0;
  logic          pc_write, pc_redirect, ifid_write, if_flush, idex_bubble;
  logic [31:0]   redirect_pc;
  logic [W-1:0]  stall_cycles;

  int errors = 0;
  int checks = 0;

  bit          m_wait;
  logic [31:0] m_pend;
  int          m_stall;

  if_fetch_ctrl #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_write(pc_write), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .ifid_write(ifid_write), .if_flush(if_flush), .idex_bubble(idex_bubble),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for the mid-cycle sample point, checks against the model, then advances the model.
  task automatic check();
    bit lu, e_pw, e_red, e_iw, e_fl, e_bub, iw_defined, n_wait;
    logic [31:0] e_rpc, n_pend;
    @(negedge clk);
    if (!rst_n) begin
      m_wait = 0; m_pend = '0; m_stall = 0;
      chk("rst pc_write", 32'(pc_write), 0);
      chk("rst ifid_write", 32'(ifid_write), 0);
      chk("rst if_flush", 32'(if_flush), 1);
      chk("rst idex_bubble", 32'(idex_bubble), 1);
      chk("rst pc_redirect", 32'(pc_redirect), 0);
      chk("rst redirect_pc", redirect_pc, 0);
      chk("rst stall_cycles", 32'(stall_cycles), 0);
    end else begin
      lu = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
      e_pw = 1; e_red = 0; e_rpc = m_pend; e_iw = 1; e_fl = 0; e_bub = 0;
      iw_defined = 1; n_wait = m_wait; n_pend = m_pend;
      if (lu) begin
        e_pw = 0; e_iw = 0; e_bub = 1;
      end else if (!m_wait && branch_taken) begin
        iw_defined = 0; e_fl = 1;
        if (imem_ready) begin e_red = 1; e_rpc = branch_target; end
        else begin e_pw = 0; n_wait = 1; n_pend = branch_target; end
      end else if (m_wait) begin
        iw_defined = 0; e_fl = 1;
        if (imem_ready) begin e_red = 1; n_wait = 0; end
        else e_pw = 0;
      end else if (!imem_ready) begin
        e_pw = 0; e_iw = 0; e_fl = 1;
      end
      chk("pc_write", 32'(pc_write), 32'(e_pw));
      chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
      chk("redirect_pc", redirect_pc, e_rpc);
      chk("if_flush", 32'(if_flush), 32'(e_fl));
      chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
      if (iw_defined) chk("ifid_write", 32'(ifid_write), 32'(e_iw));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      if (!e_pw && m_stall < SMAX) m_stall++;
      m_wait = n_wait; m_pend = n_pend;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit mr, input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                     input bit bt, input logic [31:0] tgt, input bit rdy);
    rst_n = 1'b1; idex_memread = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
    branch_taken = bt; branch_target = tgt; imem_ready = rdy;
    check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; branch_taken = 1'b0; idex_memread = 1'b0; imem_ready = 1'b1;
    check();
    adv();
  endtask

  initial begin
    do_reset();

    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit normal pc_write", 32'(pc_write), 1); adv();

    // load-use on rs
    cyc(1, 8, 8, 3, 0, 0, 1);
    chk("lit lu pc_write", 32'(pc_write), 0);
    chk("lit lu ifid_write", 32'(ifid_write), 0);
    chk("lit lu idex_bubble", 32'(idex_bubble), 1); adv();
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit lu stall +1", 32'(stall_cycles), 1); adv();

    // r0 load never stalls; then load-use on rt
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("lit r0 pc_write", 32'(pc_write), 1);
    chk("lit r0 ifid_write", 32'(ifid_write), 1); adv();
    cyc(1, 9, 2, 9, 0, 0, 1); adv();
    cyc(1, 9, 2, 4, 0, 0, 1); adv();

    // taken branch with imem ready
    cyc(0, 0, 0, 0, 1, 32'h0040_0100, 1);
    chk("lit br pc_redirect", 32'(pc_redirect), 1);
    chk("lit br redirect_pc", redirect_pc, 32'h0040_0100);
    chk("lit br if_flush", 32'(if_flush), 1); adv();
    cyc(0, 0, 0, 0, 0, 0, 1); adv();

    // taken branch while imem busy for 3 cycles
    do_reset();
    cyc(0, 0, 0, 0, 1, 32'h0040_0200, 0);
    chk("lit wait1 if_flush", 32'(if_flush), 1); adv();
    cyc(0, 0, 0, 0, 0, 32'h1234_5678, 0);
    chk("lit wait2 if_flush", 32'(if_flush), 1); adv();
    cyc(0, 0, 0, 0, 0, 32'h1234_5678, 0);
    chk("lit wait3 pc_redirect", 32'(pc_redirect), 0);
    chk("lit wait3 redirect_pc", redirect_pc, 32'h0040_0200); adv();
    cyc(0, 0, 0, 0, 0, 32'h1234_5678, 1);
    chk("lit wait4 pc_redirect", 32'(pc_redirect), 1);
    chk("lit wait4 redirect_pc", redirect_pc, 32'h0040_0200);
    chk("lit wait4 if_flush", 32'(if_flush), 1); adv();
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit wait stall=3", 32'(stall_cycles), 3); adv();

    // load-use and branch together: lu wins, branch taken next cycle
    cyc(1, 7, 7, 0, 1, 32'h0000_0abc, 1);
    chk("lit lu+br pc_redirect", 32'(pc_redirect), 0);
    chk("lit lu+br if_flush", 32'(if_flush), 0);
    chk("lit lu+br idex_bubble", 32'(idex_bubble), 1); adv();
    cyc(0, 7, 7, 0, 1, 32'h0000_0abc, 1);
    chk("lit br retry redirect_pc", redirect_pc, 32'h0000_0abc); adv();

    // reset during pending redirect discards it
    cyc(0, 0, 0, 0, 1, 32'h0040_0300, 0); adv();
    cyc(0, 0, 0, 0, 0, 0, 0); adv();
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit post-rst pc_redirect", 32'(pc_redirect), 0);
    chk("lit post-rst stall", 32'(stall_cycles), 0); adv();

    // imem stall in RUN, long enough to saturate the counter
    for (int i = 0; i < SMAX + 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      adv();
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit saturate", 32'(stall_cycles), SMAX); adv();
    cyc(0, 0, 0, 0, 0, 0, 1); adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
